// File: rtl/four_down_counter.sv
// Loadable 4-bit down counter with a two-state IDLE/RUN controller and underflow borrow pulse.
// Latency: q, borrow and busy update one clock after load/enable; zero is decoded combinationally from q.
// No backpressure: load and enable are sampled every cycle. Define FOUR_DOWN_COUNTER_AUTORELOAD_EN to reload on underflow.
module four_down_counter #(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       load,
    input  logic [3:0] din,
    input  logic       enable,
    output logic [3:0] q,
    output logic       zero,
    output logic       borrow,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] q_nxt;
    logic       borrow_nxt;

`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
    logic [3:0] reload;
    logic [3:0] reload_nxt;
`endif

    // Load wins over enable; enable only counts once the first load has moved us into RUN.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        borrow_nxt = 1'b0;
`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
        reload_nxt = reload;
`endif
        if (load) begin
            q_nxt     = din;
            state_nxt = RUN;
`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
            reload_nxt = din;
`endif
        end else if ((state == RUN) && enable) begin
            if (q == 4'h0) begin
                borrow_nxt = 1'b1;
`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
                q_nxt = reload;
`else
                q_nxt = 4'hF;
`endif
            end else begin
                q_nxt = q - 4'h1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state  <= IDLE;
            q      <= RESET_VAL;
            borrow <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            borrow <= borrow_nxt;
        end
    end

`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            reload <= RESET_VAL;
        end else begin
            reload <= reload_nxt;
        end
    end
`endif

    assign zero = (q == 4'h0);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_four_down_counter.sv
// Directed-vector bench for four_down_counter: reset, count-down, priority, hold, mid-count reset, wrap stress.
module tb_four_down_counter;

    localparam logic [3:0] RV = 4'h0;

    logic       clock;
    logic       clear_n;
    logic       load;
    logic [3:0] din;
    logic       enable;
    logic [3:0] q;
    logic       zero;
    logic       borrow;
    logic       busy;

    int vectors;
    int errors;
    int borrow_cnt;

    four_down_counter #(.RESET_VAL(RV)) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .load   (load),
        .din    (din),
        .enable (enable),
        .q      (q),
        .zero   (zero),
        .borrow (borrow),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] exp_q;
        vectors = 0;
        errors  = 0;
        clear_n = 1'b1;
        load    = 1'b0;
        din     = 4'h0;
        enable  = 1'b0;

        // Reset asserted between edges must act before any edge.
        #3 clear_n = 1'b0;
        #1;
        check("rst_q", q, RV);
        check("rst_busy", {3'b0, busy}, 4'h0);
        check("rst_borrow", {3'b0, borrow}, 4'h0);
        check("rst_zero", {3'b0, zero}, 4'h1);
        tick();
        #2 clear_n = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_q", q, RV);
            check("idle_busy", {3'b0, busy}, 4'h0);
            check("idle_borrow", {3'b0, borrow}, 4'h0);
        end

        // Count down from 5 through underflow.
        enable = 1'b0;
        load   = 1'b1;
        din    = 4'h5;
        tick();
        load = 1'b0;
        check("ld5_q", q, 4'h5);
        check("ld5_busy", {3'b0, busy}, 4'h1);
        enable = 1'b1;
        exp_q  = 4'h5;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (exp_q == 4'h0) begin
`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
                exp_q = 4'h5;
`else
                exp_q = 4'hF;
`endif
                check("cd_borrow", {3'b0, borrow}, 4'h1);
            end else begin
                exp_q = exp_q - 4'h1;
                check("cd_borrow", {3'b0, borrow}, 4'h0);
            end
            check("cd_q", q, exp_q);
            check("cd_zero", {3'b0, zero}, (exp_q == 4'h0) ? 4'h1 : 4'h0);
        end

        // Load beats enable in the same cycle.
        enable = 1'b0;
        load   = 1'b1;
        din    = 4'h3;
        tick();
        check("ld3_q", q, 4'h3);
        din    = 4'hA;
        enable = 1'b1;
        tick();
        check("prio_q", q, 4'hA);
        check("prio_borrow", {3'b0, borrow}, 4'h0);

        // Hold with enable low.
        enable = 1'b0;
        din    = 4'h7;
        tick();
        load = 1'b0;
        check("ld7_q", q, 4'h7);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", q, 4'h7);
            check("hold_borrow", {3'b0, borrow}, 4'h0);
            check("hold_busy", {3'b0, busy}, 4'h1);
        end

        // Reset in the middle of a count.
        load = 1'b1;
        din  = 4'h9;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("mid_q6", q, 4'h6);
        #1 clear_n = 1'b0;
        #1;
        check("mid_rst_q", q, RV);
        check("mid_rst_busy", {3'b0, busy}, 4'h0);
        #2 clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_q", q, RV);
            check("post_rst_busy", {3'b0, busy}, 4'h0);
        end

        // Wrap stress from zero.
        load = 1'b1;
        din  = 4'h0;
        tick();
        load = 1'b0;
        check("ld0_q", q, 4'h0);
        borrow_cnt = 0;
        for (int i = 0; i < 33; i++) begin
            tick();
            if (borrow) borrow_cnt++;
        end
`ifdef FOUR_DOWN_COUNTER_AUTORELOAD_EN
        check("wrap_borrows", borrow_cnt[3:0], 4'h1);
        check("wrap_borrows_hi", {2'b0, borrow_cnt[5:4]}, 4'h2);
        check("wrap_q", q, 4'h0);
`else
        check("wrap_borrows", borrow_cnt[3:0], 4'h3);
        check("wrap_borrows_hi", {2'b0, borrow_cnt[5:4]}, 4'h0);
        check("wrap_q", q, 4'hF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/four_down_counter.md
FOUR_DOWN_COUNTER -- requirements
Module: four_down_counter

Interface
REQ-001 The block SHALL have parameter RESET_VAL, default 4'h0, giving the q value forced by reset.
REQ-002 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port clear_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port load  input  1  synchronous load strobe for din.
REQ-005 The block SHALL have port din  input  4  load value.
REQ-006 The block SHALL have port enable  input  1  count-down enable.
REQ-007 The block SHALL have port q  output  4  registered count.
REQ-008 The block SHALL have port zero  output  1  high whenever q == 4'h0 (decoded from register, no clock latency).
REQ-009 The block SHALL have port borrow  output  1  registered one-cycle pulse on underflow.
REQ-010 The block SHALL have port busy  output  1  high while the FSM is in RUN.

Function
REQ-011 The FSM SHALL have two states: IDLE (reset state, busy=0) and RUN (busy=1).
REQ-012 In IDLE, enable SHALL be ignored: q holds and borrow stays 0.
REQ-013 load=1 in either state SHALL, at the next edge, set q=din, set reload register=din, and enter or stay in RUN.
REQ-014 Load SHALL have priority over enable when both are high in the same cycle: q=din, no decrement, borrow=0.
REQ-015 In RUN with enable=1, load=0 and q != 0, q SHALL decrement by 1 per edge; borrow=0.
REQ-016 In RUN with enable=0, load=0, q SHALL hold; borrow=0.
REQ-017 In RUN with enable=1, load=0 and q == 0, borrow SHALL be 1 for exactly the following cycle, and the next q value SHALL be as set by REQ-022 and REQ-023.
REQ-018 Consecutive underflows SHALL each produce a separate one-cycle borrow pulse; borrow SHALL never be high in two adjacent cycles unless q==0 and the reload value is 0 with the reload option compiled in.
REQ-019 RUN SHALL be left only through reset; there is no return to IDLE otherwise.

Reset
REQ-020 clear_n=0 SHALL immediately, without waiting for a clock edge, force q=RESET_VAL, reload register=RESET_VAL, borrow=0, state=IDLE, busy=0, independent of load/enable/clock.
REQ-021 Reset asserted mid-count SHALL discard the count. After clear_n deasserts, the block SHALL remain in IDLE until the first load.

Configuration
REQ-022 With macro FOUR_DOWN_COUNTER_AUTORELOAD_EN undefined, underflow SHALL wrap q from 4'h0 to 4'hF, and the reload register SHALL be removed.
REQ-023 With FOUR_DOWN_COUNTER_AUTORELOAD_EN defined, underflow SHALL set q to the reload register value (last din loaded, or RESET_VAL if none). With reload value 0 and enable held high, q SHALL stay 0 and borrow SHALL be high every cycle.

Verification
REQ-024 Reset: clear_n=0 asserted at an arbitrary non-edge time -> q=RESET_VAL, busy=0 and borrow=0 before the next clock edge. After deassert with enable=1 and no load, q is unchanged for 10 cycles.
REQ-025 Count down: load din=4'h5, then enable=1 for 7 cycles -> q sequence 5,4,3,2,1,0,then F (default build) or 5 (AUTORELOAD build). borrow is high only in the cycle after q=0 was decremented. zero is high only while q=0.
REQ-026 Simultaneous events: in RUN with q=4'h3, load=1, din=4'hA and enable=1 in the same cycle -> q=4'hA next cycle, borrow=0.
REQ-027 Hold: in RUN with q=4'h7, enable=0 for 5 cycles -> q stays 7, borrow=0, busy=1.
REQ-028 Mid-operation reset: load 4'h9, count 3 cycles to q=4'h6, then pulse clear_n low for 3 ns -> q=RESET_VAL and state IDLE immediately. A subsequent enable=1 without load leaves q unchanged.
REQ-029 Wrap stress (default build): load 4'h0 with enable=1 for 33 cycles -> exactly 3 borrow pulses, and q=4'hF at the final edge.
